fetch_pc_unit: RTL and testbench

Parametrised next-generation program counter for the fetch stage. It selects the next PC from sequential, branch, JAL and JALR sources, and adds a pipeline stall hold and a resumable RUN/HALTED state machine. It traps misaligned control-flow targets to a fixed vector, recording the faulting PC. It also keeps a circular return-address stack (RAS) that fetch uses for return prediction.

---
 rtl/fetch_pc_pkg.sv | 18 +
 rtl/fetch_pc_if.sv | 46 ++++
 rtl/return_address_stack.sv | 53 +++++
 rtl/fetch_pc_unit.sv | 116 +++++++++++
 tb/tb_fetch_pc_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared types and constants for the fetch-stage program counter.
//   pc_state_t       : fetch run state (RUN / HALTED)
//   INSN_ALIGN_BITS  : low PC bits that must be zero on a control-flow target
//   DEFAULT_*        : default widths and vectors used by the unit and its interface
package fetch_pc_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_t;

  localparam int          INSN_ALIGN_BITS      = 2;
  localparam int          DEFAULT_XLEN         = 32;
  localparam int          DEFAULT_RAS_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/fetch_pc_if.sv
// Bundle of control inputs and PC/trap/RAS outputs of the fetch PC unit.
//   master : decode/execute side, drives control and targets, observes PC state
//   slave  : fetch_pc_unit, consumes control, drives PC, trap and RAS outputs
interface fetch_pc_if
  import fetch_pc_pkg::*;
#(
  parameter int XLEN      = DEFAULT_XLEN,
  parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             is_halt;
  logic             resume;
  logic             branch_taken;
  logic [XLEN-1:0]  branch_target;
  logic             is_jal;
  logic [XLEN-1:0]  imm_j;
  logic             is_jalr;
  logic [XLEN-1:0]  jalr_target;
  logic             is_call;
  logic             is_return;

  logic [XLEN-1:0]  program_counter_value;
  logic             halted;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_epc;
  logic [XLEN-1:0]  ras_top;
  logic             ras_valid;
  logic [CNT_W-1:0] ras_count;

  modport master (
    output stall, is_halt, resume, branch_taken, branch_target, is_jal, imm_j,
           is_jalr, jalr_target, is_call, is_return,
    input  program_counter_value, halted, trap_valid, trap_epc, ras_top,
           ras_valid, ras_count
  );

  modport slave (
    input  stall, is_halt, resume, branch_taken, branch_target, is_jal, imm_j,
           is_jalr, jalr_target, is_call, is_return,
    output program_counter_value, halted, trap_valid, trap_epc, ras_top,
           ras_valid, ras_count
  );

endinterface

// File: rtl/return_address_stack.sv
// Circular return-address stack with a saturating occupancy count.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, pop    : push alone pushes, pop alone pops, both replaces the top
//   push_data    : return address to store
//   top          : most recently pushed entry still on the stack
//   valid, count : stack non-empty / number of occupied entries
module return_address_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [XLEN-1:0]                push_data,
  output logic [XLEN-1:0]                top,
  output logic                           valid,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  entries [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count_q;

  // wr_ptr names the next free slot; depth is a power of two so the
  // pointer wraps naturally and a push when full overwrites the oldest entry.
  assign top_ptr = wr_ptr - PTR_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
    end else if (push && pop && (count_q != '0)) begin
      entries[top_ptr] <= push_data;
    end else if (push) begin
      entries[wr_ptr] <= push_data;
      wr_ptr          <= wr_ptr + PTR_W'(1);
      if (count_q != CNT_W'(RAS_DEPTH)) count_q <= count_q + CNT_W'(1);
    end else if (pop && (count_q != '0)) begin
      wr_ptr  <= top_ptr;
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign top   = entries[top_ptr];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: next-PC select (sequential, branch, JAL, JALR),
// stall hold, RUN/HALTED control, misaligned-target trap and return stack.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : fetch_pc_if slave (control inputs in; PC, trap, RAS out)
//
//   state  | meaning
//   RUN    | PC advances or redirects every non-stalled edge
//   HALTED | PC frozen; only resume is honoured, leaving at PC+4
module fetch_pc_unit
  import fetch_pc_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int              RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input logic       clock,
  input logic       reset,
  fetch_pc_if.slave bus
);
  localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(1) << INSN_ALIGN_BITS;

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            trap_valid_q, trap_valid_d;
  logic [XLEN-1:0] trap_epc_q, trap_epc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            jump_sel;
  logic            misaligned;
  logic            ras_push, ras_pop;

  assign pc_plus4 = pc_q + INSN_BYTES;
  assign redirect = bus.branch_taken | bus.is_jal | bus.is_jalr;
  // A taken branch outranks a simultaneous jump, so only a jump that actually
  // selects the target may touch the return stack.
  assign jump_sel = !bus.branch_taken && (bus.is_jal || bus.is_jalr);

  always_comb begin
    target = {bus.jalr_target[XLEN-1:1], 1'b0};
    if (bus.branch_taken)  target = bus.branch_target;
    else if (bus.is_jal)   target = pc_q + bus.imm_j;
  end

  assign misaligned = target[INSN_ALIGN_BITS-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      trap_valid_q <= 1'b0;
      trap_epc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      trap_valid_q <= trap_valid_d;
      trap_epc_q   <= trap_epc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    trap_valid_d = 1'b0;
    trap_epc_d   = trap_epc_q;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    case (state_q)
      RUN: begin
        if (!bus.stall) begin
          if (bus.is_halt) begin
            state_d = HALTED;
          end else if (redirect && misaligned) begin
            pc_d         = TRAP_VECTOR;
            trap_valid_d = 1'b1;
            trap_epc_d   = pc_q;
          end else if (redirect) begin
            pc_d     = target;
            ras_push = jump_sel && bus.is_call;
            ras_pop  = jump_sel && bus.is_return;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      HALTED: begin
        if (bus.resume) begin
          state_d = RUN;
          pc_d    = pc_plus4;
        end
      end
      default: state_d = RUN;
    endcase
  end

  return_address_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (bus.ras_top),
    .valid     (bus.ras_valid),
    .count     (bus.ras_count)
  );

  assign bus.program_counter_value = pc_q;
  assign bus.halted                = (state_q == HALTED);
  assign bus.trap_valid            = trap_valid_q;
  assign bus.trap_epc              = trap_epc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] TV    = 32'h100;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_pc_if #(.XLEN(32), .RAS_DEPTH(DEPTH)) bus ();

  fetch_pc_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_tv;
  logic [31:0] m_epc;
  logic [31:0] m_ras[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.is_halt = 0; bus.resume = 0;
    bus.branch_taken = 0; bus.branch_target = '0;
    bus.is_jal = 0; bus.imm_j = '0; bus.is_jalr = 0; bus.jalr_target = '0;
    bus.is_call = 0; bus.is_return = 0;
  endtask

  task automatic check_all();
    check_val("pc", bus.program_counter_value, m_pc);
    check_val("halted", {31'b0, bus.halted}, {31'b0, m_halted});
    check_val("trap_valid", {31'b0, bus.trap_valid}, {31'b0, m_tv});
    check_val("trap_epc", bus.trap_epc, m_epc);
    check_val("ras_count", 32'(bus.ras_count), 32'(m_ras.size()));
    check_val("ras_valid", {31'b0, bus.ras_valid}, {31'(0), m_ras.size() != 0});
    if (m_ras.size() != 0) check_val("ras_top", bus.ras_top, m_ras[$]);
  endtask

  // Apply the current inputs for one edge, advance the model, compare.
  task automatic step();
    logic [31:0] tgt;
    logic [31:0] link;
    bit          is_jump;
    link = m_pc + 32'd4;
    m_tv = 0;
    if (reset) begin
      m_pc = RV; m_halted = 0; m_epc = 0; m_ras.delete();
    end else if (m_halted) begin
      if (bus.resume) begin m_halted = 0; m_pc = link; end
    end else if (bus.stall) begin
      // held
    end else if (bus.is_halt) begin
      m_halted = 1;
    end else if (bus.branch_taken || bus.is_jal || bus.is_jalr) begin
      is_jump = 0;
      if (bus.branch_taken) tgt = bus.branch_target;
      else begin
        is_jump = 1;
        if (bus.is_jal) tgt = m_pc + bus.imm_j;
        else            tgt = bus.jalr_target & ~32'd1;
      end
      if (tgt % 4 >= 2) begin
        m_epc = m_pc; m_pc = TV; m_tv = 1;
      end else begin
        m_pc = tgt;
        if (is_jump && bus.is_call && bus.is_return) begin
          if (m_ras.size() == 0) m_ras.push_back(link);
          else m_ras[m_ras.size()-1] = link;
        end else if (is_jump && bus.is_call) begin
          if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(link);
        end else if (is_jump && bus.is_return) begin
          if (m_ras.size() != 0) void'(m_ras.pop_back());
        end
      end
    end else begin
      m_pc = link;
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    clear_inputs();
    bus.branch_taken = 1; bus.branch_target = addr;
    step();
    clear_inputs();
  endtask

  initial begin
    logic [31:0] call_pcs [5];
    logic [31:0] pop_exp  [4];
    call_pcs = '{32'h0, 32'h100, 32'h200, 32'h300, 32'h400};
    pop_exp  = '{32'h404, 32'h304, 32'h204, 32'h104};
    clear_inputs();
    m_pc = 32'hx; m_halted = 0; m_tv = 0; m_epc = 0;

    // reset and free run
    reset = 1; step();
    check_val("reset_pc", bus.program_counter_value, 32'h0);
    reset = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_val("free_pc", bus.program_counter_value, 32'(4 * i));
    end
    reset = 1; step(); reset = 0;
    check_val("midrun_reset_pc", bus.program_counter_value, 32'h0);
    check_val("midrun_reset_cnt", 32'(bus.ras_count), 32'h0);

    // branch and stall
    goto_pc(32'h40);
    bus.branch_taken = 1; bus.branch_target = 32'h80; bus.stall = 1;
    step();
    check_val("stall_hold", bus.program_counter_value, 32'h40);
    bus.stall = 0; step(); clear_inputs();
    check_val("branch_pc", bus.program_counter_value, 32'h80);

    // call then return
    goto_pc(32'h10);
    bus.is_jal = 1; bus.is_call = 1; bus.imm_j = 32'h20; step(); clear_inputs();
    check_val("jal_pc", bus.program_counter_value, 32'h30);
    check_val("call_top", bus.ras_top, 32'h14);
    bus.is_jalr = 1; bus.is_return = 1; bus.jalr_target = 32'h14; step(); clear_inputs();
    check_val("ret_cnt", 32'(bus.ras_count), 32'h0);
    check_val("ret_valid", {31'b0, bus.ras_valid}, 32'h0);

    // overflow overwrites the oldest entry
    foreach (call_pcs[i]) begin
      goto_pc(call_pcs[i]);
      bus.is_jal = 1; bus.is_call = 1; bus.imm_j = 32'h1000; step(); clear_inputs();
    end
    check_val("full_cnt", 32'(bus.ras_count), 32'd4);
    check_val("full_top", bus.ras_top, 32'h404);
    foreach (pop_exp[i]) begin
      check_val("pop_top", bus.ras_top, pop_exp[i]);
      bus.is_jalr = 1; bus.is_return = 1; bus.jalr_target = 32'h800; step(); clear_inputs();
    end
    check_val("drained_cnt", 32'(bus.ras_count), 32'h0);

    // misaligned jalr traps, bit0 alone does not
    goto_pc(32'h50);
    bus.is_jalr = 1; bus.is_call = 1; bus.jalr_target = 32'h62; step(); clear_inputs();
    check_val("trap_pc", bus.program_counter_value, 32'h100);
    check_val("trap_pulse", {31'b0, bus.trap_valid}, 32'h1);
    check_val("trap_epc_val", bus.trap_epc, 32'h50);
    check_val("trap_no_push", 32'(bus.ras_count), 32'h0);
    bus.is_jalr = 1; bus.jalr_target = 32'h61; step(); clear_inputs();
    check_val("jalr_bit0_pc", bus.program_counter_value, 32'h60);
    check_val("trap_pulse_end", {31'b0, bus.trap_valid}, 32'h0);
    check_val("trap_epc_hold", bus.trap_epc, 32'h50);

    // halt / resume
    goto_pc(32'h20);
    bus.is_halt = 1; step(); clear_inputs();
    check_val("halt_flag", {31'b0, bus.halted}, 32'h1);
    bus.branch_taken = 1; bus.branch_target = 32'h200;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("halt_hold", bus.program_counter_value, 32'h20);
    end
    clear_inputs(); bus.resume = 1; step(); clear_inputs();
    check_val("resume_pc", bus.program_counter_value, 32'h24);
    check_val("resume_flag", {31'b0, bus.halted}, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      clear_inputs();
      reset = ($urandom_range(0, 59) == 0);
      bus.stall   = ($urandom_range(0, 5) == 0);
      bus.is_halt = ($urandom_range(0, 19) == 0);
      bus.resume  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: begin bus.branch_taken = 1; end
        1: begin bus.is_jal = 1; end
        2: begin bus.is_jalr = 1; end
        3: begin bus.is_jal = $urandom_range(0, 1); bus.is_jalr = 1; bus.branch_taken = 1; end
        default: ;
      endcase
      bus.branch_target = {$urandom_range(0, 32'h3FFF), 2'b00} | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
      bus.imm_j         = {$urandom_range(0, 32'h3FFF), 2'b00} | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
      bus.jalr_target   = {$urandom_range(0, 32'h3FFF), 2'b00} | 32'($urandom_range(0, 1))
                          | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
      bus.is_call   = $urandom_range(0, 1);
      bus.is_return = $urandom_range(0, 1);
      step();
    end
    reset = 0;
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
